// File: rtl/uart_alu_frame_ctrl_pkg.sv
// Shared types and constants for the UART <-> ALU frame controller.
package uart_alu_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_A,
        ST_RX_OP,
        ST_RX_B,
        ST_EXEC,
        ST_TX_LOAD,
        ST_TX_WAIT
    } state_e;

    // ASCII characters accepted as operators
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_SUB = 8'h2D;
    localparam logic [7:0] CH_AND = 8'h26;
    localparam logic [7:0] CH_OR  = 8'h7C;
    localparam logic [7:0] CH_XOR = 8'h5E;
    localparam logic [7:0] CH_NOR = 8'h7E;
    localparam logic [7:0] CH_SRA = 8'h3E;
    localparam logic [7:0] CH_SRL = 8'h3C;

    // ALU opcode values
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_SRL = 8'h02;

endpackage

// File: rtl/uart_alu_frame_ctrl_decode.sv
// Combinational ASCII operator character to ALU opcode decoder.
module ascii_op_decode
    import uart_alu_frame_ctrl_pkg::*;
#(
    parameter int OP_W = 8
) (
    input  logic [7:0]      char_i,
    output logic [OP_W-1:0] op_o,
    output logic            valid_o
);

    always_comb begin
        op_o    = '0;
        valid_o = 1'b1;
        case (char_i)
            CH_ADD:  op_o = OP_W'(OP_ADD);
            CH_SUB:  op_o = OP_W'(OP_SUB);
            CH_AND:  op_o = OP_W'(OP_AND);
            CH_OR:   op_o = OP_W'(OP_OR);
            CH_XOR:  op_o = OP_W'(OP_XOR);
            CH_NOR:  op_o = OP_W'(OP_NOR);
            CH_SRA:  op_o = OP_W'(OP_SRA);
            CH_SRL:  op_o = OP_W'(OP_SRL);
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Frame controller: collects A/op/B bytes from the UART, drives the ALU,
// waits a fixed latency and serialises the result (or an error byte) back.
module uart_alu_frame_ctrl
    import uart_alu_frame_ctrl_pkg::*;
#(
    parameter int         OPND_BYTES  = 1,
    parameter int         OP_W        = 8,
    parameter int         ALU_LAT     = 1,
    parameter int         TIMEOUT_CYC = 0,
    parameter logic [7:0] ERR_CHAR    = 8'h3F,
    localparam int        OW          = 8 * OPND_BYTES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      d_in,
    input  logic            rx_done,
    input  logic            tx_done,
    input  logic [OW-1:0]   d_in_alu,
    output logic [7:0]      d_out,
    output logic            tx_start,
    output logic [OW-1:0]   A,
    output logic [OW-1:0]   B,
    output logic [OP_W-1:0] opcode,
    output logic            busy,
    output logic            frame_err
);

    localparam int              CW        = 3;
    localparam int              TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]   LAST_BYTE = CW'(OPND_BYTES - 1);
    localparam logic [3:0]      LAT_LAST  = 4'(ALU_LAT - 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [OW-1:0]   ERR_WORD  = OW'(ERR_CHAR) << (OW - 8);

    state_e          state_q, state_d;
    logic [OW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            opv_q, opv_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d, tx_left_q, tx_left_d;
    logic [3:0]      lat_cnt_q, lat_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]      d_out_q, d_out_d;
    logic            tx_start_q, tx_start_d;

    logic [OP_W-1:0] dec_op;
    logic            dec_valid;
    logic            timed, to_exp, last_byte, lat_done;

    ascii_op_decode #(.OP_W(OP_W)) u_dec (
        .char_i  (d_in),
        .op_o    (dec_op),
        .valid_o (dec_valid)
    );

    function automatic logic [OW-1:0] shift_in(input logic [OW-1:0] v, input logic [7:0] b);
        return OW'({v, b});
    endfunction

    assign timed     = (state_q == ST_RX_A) || (state_q == ST_RX_OP) || (state_q == ST_RX_B);
    assign to_exp    = (TIMEOUT_CYC > 0) && timed && (to_cnt_q == TO_LAST);
    assign last_byte = (byte_cnt_q == LAST_BYTE);
    assign lat_done  = (lat_cnt_q == LAT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // A byte arriving in the same cycle as expiry takes priority over the abort
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (rx_done) state_d = (OPND_BYTES == 1) ? ST_RX_OP : ST_RX_A;
            ST_RX_A: begin
                if (rx_done) begin
                    if (last_byte) state_d = ST_RX_OP;
                end else if (to_exp) state_d = ST_IDLE;
            end
            ST_RX_OP: begin
                if (rx_done)     state_d = ST_RX_B;
                else if (to_exp) state_d = ST_IDLE;
            end
            ST_RX_B: begin
                if (rx_done) begin
                    if (last_byte) state_d = ST_EXEC;
                end else if (to_exp) state_d = ST_IDLE;
            end
            ST_EXEC:    if (lat_done) state_d = ST_TX_LOAD;
            ST_TX_LOAD: state_d = ST_TX_WAIT;
            ST_TX_WAIT: if (tx_done) state_d = (tx_left_q == '0) ? ST_IDLE : ST_TX_LOAD;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        frame_err = to_exp && !rx_done;
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        opv_d      = opv_q;
        byte_cnt_d = byte_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        res_d      = res_q;
        tx_left_d  = tx_left_q;
        d_out_d    = d_out_q;
        tx_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_done) begin
                    a_d        = shift_in(a_q, d_in);
                    byte_cnt_d = (OPND_BYTES == 1) ? '0 : CW'(1);
                end
            end
            ST_RX_A: begin
                if (rx_done) begin
                    a_d        = shift_in(a_q, d_in);
                    byte_cnt_d = last_byte ? '0 : byte_cnt_q + CW'(1);
                end
            end
            ST_RX_OP: begin
                if (rx_done) begin
                    op_d  = dec_op;
                    opv_d = dec_valid;
                end
            end
            ST_RX_B: begin
                if (rx_done) begin
                    b_d        = shift_in(b_q, d_in);
                    byte_cnt_d = last_byte ? '0 : byte_cnt_q + CW'(1);
                    lat_cnt_d  = '0;
                end
            end
            ST_EXEC: begin
                lat_cnt_d = lat_cnt_q + 4'd1;
                if (lat_done) begin
                    res_d     = opv_q ? d_in_alu : ERR_WORD;
                    tx_left_d = opv_q ? CW'(OPND_BYTES) : CW'(1);
                    lat_cnt_d = '0;
                end
            end
            ST_TX_LOAD: begin
                d_out_d    = res_q[OW-1 -: 8];
                res_d      = res_q << 8;
                tx_left_d  = tx_left_q - CW'(1);
                tx_start_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Idle-cycle counter only runs while a frame is being received
    always_comb begin
        to_cnt_d = '0;
        if (TIMEOUT_CYC > 0 && timed && !rx_done && !to_exp) to_cnt_d = to_cnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            opv_q      <= 1'b0;
            byte_cnt_q <= '0;
            lat_cnt_q  <= '0;
            to_cnt_q   <= '0;
            res_q      <= '0;
            tx_left_q  <= '0;
            d_out_q    <= '0;
            tx_start_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            opv_q      <= opv_d;
            byte_cnt_q <= byte_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            to_cnt_q   <= to_cnt_d;
            res_q      <= res_d;
            tx_left_q  <= tx_left_d;
            d_out_q    <= d_out_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign d_out    = d_out_q;
    assign tx_start = tx_start_q;
    assign A        = a_q;
    assign B        = b_q;
    assign opcode   = op_q;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Directed and randomized frames against a behavioural frame/ALU model.
module tb_uart_alu_frame_ctrl;

    localparam int         NB  = 2;
    localparam int         OW  = 8 * NB;
    localparam int         LAT = 3;
    localparam int         TO  = 50;
    localparam logic [7:0] ERR = 8'h3F;

    logic          clk = 1'b0, reset = 1'b0, rx_done = 1'b0, tx_done = 1'b0;
    logic [7:0]    d_in = 8'h00;
    logic [OW-1:0] d_in_alu;
    logic [7:0]    d_out, opcode;
    logic          tx_start, busy, frame_err;
    logic [OW-1:0] A, B;

    int n_chk = 0, n_fail = 0, tx_cnt = 0, ferr_cnt = 0;
    logic prev_start = 1'b0;

    always #5 clk = ~clk;

    uart_alu_frame_ctrl #(.OPND_BYTES(NB), .OP_W(8), .ALU_LAT(LAT), .TIMEOUT_CYC(TO), .ERR_CHAR(ERR)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .rx_done(rx_done), .tx_done(tx_done),
        .d_in_alu(d_in_alu), .d_out(d_out), .tx_start(tx_start), .A(A), .B(B),
        .opcode(opcode), .busy(busy), .frame_err(frame_err)
    );

    function automatic logic [15:0] alu_f(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            8'h20:   return a + b;
            8'h22:   return a - b;
            8'h24:   return a & b;
            8'h25:   return a | b;
            8'h26:   return a ^ b;
            8'h27:   return ~(a | b);
            8'h03:   return $unsigned($signed(a) >>> b[3:0]);
            8'h02:   return a >> b[3:0];
            default: return 16'h0000;
        endcase
    endfunction

    // {valid, opcode} for an operator character
    function automatic logic [8:0] dec_f(input logic [7:0] c);
        case (c)
            8'h2B:   return {1'b1, 8'h20};
            8'h2D:   return {1'b1, 8'h22};
            8'h26:   return {1'b1, 8'h24};
            8'h7C:   return {1'b1, 8'h25};
            8'h5E:   return {1'b1, 8'h26};
            8'h7E:   return {1'b1, 8'h27};
            8'h3E:   return {1'b1, 8'h03};
            8'h3C:   return {1'b1, 8'h02};
            default: return {1'b0, 8'h00};
        endcase
    endfunction

    always_comb d_in_alu = alu_f(opcode, A, B);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            tx_cnt++;
            chk("tx_start_back_to_back", {31'b0, prev_start}, 32'd0);
        end
        if (frame_err === 1'b1) ferr_cnt++;
        prev_start = tx_start;
    end

    task automatic send_byte(input logic [7:0] b);
        d_in    = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [7:0] oc, input logic [15:0] b, input int maxgap);
        send_byte(a[15:8]); idle($urandom_range(0, maxgap));
        send_byte(a[7:0]);  idle($urandom_range(0, maxgap));
        send_byte(oc);      idle($urandom_range(0, maxgap));
        send_byte(b[15:8]); idle($urandom_range(0, maxgap));
        send_byte(b[7:0]);
    endtask

    // Called on the negedge of cycle c0 after the last B byte (cycle 0)
    task automatic expect_reply(input string tag, input logic [15:0] a, input logic [7:0] oc,
                                input logic [15:0] b, input bit lat_chk, input bit stray, input int c0);
        logic [8:0]  d;
        logic [15:0] r;
        logic [7:0]  eb [2];
        int n, c, t0;
        d = dec_f(oc);
        r = alu_f(d[7:0], a, b);
        if (d[8]) begin eb[0] = r[15:8]; eb[1] = r[7:0]; n = 2; end
        else      begin eb[0] = ERR;     eb[1] = 8'h00;  n = 1; end
        t0 = tx_cnt;
        c  = c0;
        while (tx_start !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        chk({tag, "_first_start"}, {31'b0, tx_start}, 32'd1);
        if (lat_chk) chk({tag, "_latency"}, c, LAT + 2);
        chk({tag, "_A"}, A, a);
        chk({tag, "_B"}, B, b);
        chk({tag, "_opcode"}, opcode, d[7:0]);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_d_out"}, d_out, eb[i]);
            idle($urandom_range(0, 3));
            if (stray) send_byte(8'($urandom));
            chk({tag, "_d_out_hold"}, d_out, eb[i]);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            @(negedge clk);
            if (i < n - 1) chk({tag, "_next_start"}, {31'b0, tx_start}, 32'd1);
        end
        chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        idle(10);
        chk({tag, "_tx_count"}, tx_cnt - t0, n);
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [15:0] ra, rb;
        logic [7:0]  roc;
        int c, t0, f0;
        bit st;
        ops = '{8'h2B, 8'h2D, 8'h26, 8'h7C, 8'h5E, 8'h7E, 8'h3E, 8'h3C};

        idle(3);
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_flags", {29'b0, tx_start, busy, frame_err}, 0);
        reset = 1'b1;
        idle(2);

        send_frame(16'h0005, 8'h2B, 16'h0003, 0);
        expect_reply("add", 16'h0005, 8'h2B, 16'h0003, 1, 0, 1);

        send_frame(16'h1234, 8'h2D, 16'h0034, 3);
        expect_reply("sub", 16'h1234, 8'h2D, 16'h0034, 1, 0, 1);

        send_frame(16'h0005, 8'h41, 16'h0003, 2);
        expect_reply("badop", 16'h0005, 8'h41, 16'h0003, 1, 0, 1);

        // Silence after the operator: abort on the TO-th idle cycle
        t0 = tx_cnt; f0 = ferr_cnt;
        send_byte(8'h00); send_byte(8'h05); send_byte(8'h2B);
        c = 1;
        while (frame_err !== 1'b1 && c < TO + 10) begin @(negedge clk); c++; end
        chk("timeout_cycle", c, TO);
        @(negedge clk);
        chk("timeout_pulse_len", {31'b0, frame_err}, 0);
        chk("timeout_busy", {31'b0, busy}, 0);
        chk("timeout_A_kept", A, 16'h0005);
        chk("timeout_op_kept", opcode, 8'h20);
        idle(5);
        chk("timeout_no_tx", tx_cnt - t0, 0);
        chk("timeout_ferr_count", ferr_cnt - f0, 1);
        send_frame(16'h0007, 8'h26, 16'h0003, 2);
        expect_reply("after_to", 16'h0007, 8'h26, 16'h0003, 1, 0, 1);

        // Reset while waiting for the first tx_done of a 2-byte reply
        send_frame(16'h1234, 8'h2B, 16'h1111, 2);
        c = 1;
        while (tx_start !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        chk("rst_mid_start_seen", {31'b0, tx_start}, 1);
        idle(1);
        t0 = tx_cnt;
        reset = 1'b0;
        #1;
        chk("rst_mid_A", A, 0);
        chk("rst_mid_B", B, 0);
        chk("rst_mid_opcode", opcode, 0);
        chk("rst_mid_d_out", d_out, 0);
        chk("rst_mid_flags", {29'b0, tx_start, busy, frame_err}, 0);
        idle(3);
        reset = 1'b1;
        idle(20);
        chk("rst_mid_no_reissue", tx_cnt - t0, 0);
        send_frame(16'h00F0, 8'h7C, 16'h0F00, 2);
        expect_reply("after_rst", 16'h00F0, 8'h7C, 16'h0F00, 1, 0, 1);

        // Stray bytes in EXEC and TX_WAIT are dropped
        send_frame(16'hA5A5, 8'h5E, 16'h0FF0, 1);
        send_byte(8'h2D);
        expect_reply("stray", 16'hA5A5, 8'h5E, 16'h0FF0, 0, 1, 2);

        // Byte arriving on the expiry cycle is accepted
        f0 = ferr_cnt;
        send_byte(8'h00); send_byte(8'h05); send_byte(8'h2B);
        idle(TO - 1);
        d_in = 8'h00; rx_done = 1'b1;
        #1;
        chk("coinc_no_ferr", {31'b0, frame_err}, 0);
        @(negedge clk);
        rx_done = 1'b0;
        chk("coinc_busy", {31'b0, busy}, 1);
        send_byte(8'h03);
        expect_reply("coinc", 16'h0005, 8'h2B, 16'h0003, 1, 0, 1);
        chk("coinc_ferr_count", ferr_cnt - f0, 0);

        for (int k = 0; k < 10; k++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            c   = $urandom_range(0, 9);
            roc = (c < 8) ? ops[c] : 8'($urandom);
            st  = 1'($urandom);
            send_frame(ra, roc, rb, 6);
            if (st) send_byte(8'($urandom));
            expect_reply("rand", ra, roc, rb, !st, st, st ? 2 : 1);
        end

        chk("total_frame_err", ferr_cnt, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
